// File: rtl/cdc_pkg.sv
// Shared constants and state type for the req/ack bus-crossing pair.
// Used by both the source-side and destination-side handshake blocks.
package cdc_pkg;

    localparam int CDC_WIDTH   = 8;
    localparam int CDC_CNT_W   = 16;
    localparam int CDC_TMO_CYC = 1023;

    // 2'd3 is unused and treated as illegal.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ACK  = 2'd2
    } cdc_state_e;

    // Width of a saturating timer that must reach cyc; at least 1 bit.
    function automatic int tmo_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/cdc_wrap_cnt.sv
// Free-running wrap-around up-counter with increment enable.
// Counts completed transfers; never saturates.
module cdc_wrap_cnt
    import cdc_pkg::*;
#(
    parameter int CNT_W = CDC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: step by one on enable, wrap naturally at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cdc_hs_dst.sv
// Destination half of a 4-phase req/ack bus crossing.
// Captures the source-held word, hands it downstream, then returns ack.
module cdc_hs_dst
    import cdc_pkg::*;
#(
    parameter int WIDTH   = CDC_WIDTH,
    parameter int CNT_W   = CDC_CNT_W,
    parameter int TMO_CYC = CDC_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_sync,
    input  logic [WIDTH-1:0] src_data,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             proto_err,
    output logic             tmo_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int            TW       = tmo_w(TMO_CYC);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    cdc_state_e       state_q, state_d;
    logic             ack_q, ack_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             perr_q, perr_d;
    logic             tmo_q, tmo_d;
    logic             warned_q, warned_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             xfer_inc;

    assign xfer_inc = (state_q == ST_HOLD) && valid_q && out_ready;

    // Handshake FSM: next state, capture, error pulses and ACK timer.
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        valid_d  = valid_q;
        data_d   = data_q;
        perr_d   = 1'b0;
        tmo_d    = 1'b0;
        warned_d = warned_q;
        tmr_d    = '0;
        case (state_q)
            ST_IDLE: begin
                ack_d    = 1'b0;
                valid_d  = 1'b0;
                warned_d = 1'b0;
                if (req_sync) begin
                    data_d  = src_data;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Source dropped req before seeing ack: flag once, still deliver.
                if (!req_sync && !warned_q) begin
                    perr_d   = 1'b1;
                    warned_d = 1'b1;
                end
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (TMO_CYC != 0) begin
                    tmr_d = (tmr_q == TMO_MAX) ? tmr_q : tmr_q + 1'b1;
                    if (tmr_q == TMO_LAST) begin
                        tmo_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ack_d    = 1'b0;
                valid_d  = 1'b0;
                data_d   = '0;
                warned_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any held word and ack at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            tmo_q    <= 1'b0;
            warned_q <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            tmo_q    <= tmo_d;
            warned_q <= warned_d;
            tmr_q    <= tmr_d;
        end
    end

    cdc_wrap_cnt #(
        .CNT_W (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (xfer_inc),
        .cnt_o (xfer_cnt)
    );

    assign ack       = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign proto_err = perr_q;
    assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_cdc_hs_dst.sv
// Self-checking bench for cdc_hs_dst: vector table, corner sequences,
// and random traffic against a transfer-level reference model.
module tb_cdc_hs_dst;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_sync = 1'b0;
    logic [W-1:0]  src_data = '0;
    logic          out_ready = 1'b0;
    logic          ack;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          proto_err;
    logic          tmo_err;
    logic [CW-1:0] xfer_cnt;

    cdc_hs_dst #(
        .WIDTH   (W),
        .CNT_W   (CW),
        .TMO_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_sync  (req_sync),
        .src_data  (src_data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .proto_err (proto_err),
        .tmo_err   (tmo_err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a word is either waiting downstream, or has been
    // taken and we are waiting for the source to drop req.
    bit           m_word_waiting;
    bit           m_taken;
    bit           m_warned;
    bit           m_proto;
    bit           m_tmo;
    logic [W-1:0] m_data;
    int           m_wait;
    int           m_cnt;

    task automatic model_reset();
        m_word_waiting = 0;
        m_taken = 0;
        m_warned = 0;
        m_proto = 0;
        m_tmo = 0;
        m_data = '0;
        m_wait = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        m_proto = 0;
        m_tmo = 0;
        if (m_word_waiting) begin
            if (!req_sync && !m_warned) begin
                m_proto = 1;
                m_warned = 1;
            end
            if (out_ready) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_word_waiting = 0;
                m_taken = 1;
                m_wait = 0;
            end
        end else if (m_taken) begin
            if (!req_sync) begin
                m_taken = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) m_tmo = 1;
            end
        end else if (req_sync) begin
            m_word_waiting = 1;
            m_data = src_data;
            m_warned = 0;
        end
    endtask

    task automatic check_model();
        chk("valid", out_valid, m_word_waiting);
        chk("data", out_data, m_data);
        chk("ack", ack, m_taken);
        chk("proto_err", proto_err, m_proto);
        chk("tmo_err", tmo_err, m_tmo);
        chk("xfer_cnt", xfer_cnt, m_cnt);
    endtask

    task automatic drive(input bit r, input logic [W-1:0] d, input bit rdy);
        req_sync = r;
        src_data = d;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        drive(0, '0, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           r;
        logic [W-1:0] d;
        bit           rdy;
        bit           ev;
        logic [W-1:0] ed;
        bit           ea;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t tbl[14];

    int p;
    int a;
    int t;
    int t_at;
    bit rr;

    initial begin
        // single transfer, ready already high
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 4'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd1};
        // backpressure for 5 cycles, source bus changes underneath
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd1};
        tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 4'd2};
        tbl[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 4'd2};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd2};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd2};

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_tmo", tmo_err, 0);
        chk("rst_cnt", xfer_cnt, 0);
        do_reset();

        // vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].d, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ea);
            chk($sformatf("tbl%0d_cnt", i), xfer_cnt, tbl[i].ec);
            chk($sformatf("tbl%0d_err", i), {proto_err, tmo_err}, 0);
        end

        // early req drop while held downstream
        p = 0;
        drive(1, 8'h3C, 0);
        tick();
        drive(0, 8'h3C, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            p += proto_err;
        end
        drive(0, 8'h3C, 1);
        tick();
        p += proto_err;
        a = ack;
        chk("early_word", out_data, 8'h3C);
        drive(0, 8'h00, 0);
        tick();
        a += ack;
        tick();
        a += ack;
        chk("early_perr_pulses", p, 1);
        chk("early_ack_cycles", a, 1);

        // req falls on the same edge the word is accepted
        drive(1, 8'h77, 0);
        tick();
        drive(0, 8'h77, 1);
        tick();
        chk("sim_perr", proto_err, 1);
        a = ack;
        drive(0, 8'h00, 0);
        tick();
        a += ack;
        tick();
        a += ack;
        chk("sim_ack_cycles", a, 1);
        chk("sim_cnt", xfer_cnt, 4);

        // ACK timeout with req held high
        drive(1, 8'hC3, 0);
        tick();
        drive(1, 8'hC3, 1);
        tick();
        drive(1, 8'hC3, 0);
        t = 0;
        t_at = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tmo_err) begin
                t++;
                t_at = i + 1;
            end
        end
        chk("tmo_pulses", t, 1);
        chk("tmo_at_cycle", t_at, TMO);
        chk("tmo_ack_held", ack, 1);
        drive(0, 8'h00, 0);
        tick();
        chk("tmo_ack_drop", ack, 0);

        // async reset while a word is held
        drive(1, 8'h5E, 0);
        tick();
        chk("hold_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_cnt", xfer_cnt, 0);
        model_reset();
        drive(0, 8'h00, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 8'h99, 1);
        tick();
        chk("postrst_data", out_data, 8'h99);
        tick();
        drive(0, 8'h00, 0);
        tick();
        chk("postrst_cnt", xfer_cnt, 1);

        // counter wrap over 17 back-to-back transfers
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, W'(i), 1);
            tick();
            tick();
            drive(0, 8'h00, 1);
            tick();
        end
        chk("wrap_cnt", xfer_cnt, 1);

        // random traffic with sticky req to reach timeouts now and then
        rr = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) rr = ~rr;
            drive(rr, W'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
